serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that computes `a - b` on two WIDTH-bit operands using a single full-subtractor cell, built from two half-subtractor stages plus an OR of their borrows, and a registered borrow. It sequences operands LSB-first through the cell, one bit per clock. It presents a start/busy/done handshake to the surrounding logic. It sits between a requester that supplies operands and the shared subtractor cell, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are WIDTH >= 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new subtraction; sampled only in IDLE or DONE.
- `a`  in  WIDTH: minuend; captured on the accepting edge only.
- `b`  in  WIDTH: subtrahend; captured on the accepting edge only.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: single-cycle pulse; high while state is DONE.
- `dif`  out  WIDTH: difference `a - b` modulo 2^WIDTH; valid while `done` is high and held until the next accepted start.
- `bor`  out  1: final borrow out; 1 iff a < b unsigned. Same validity as `dif`.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `start`=1 loads the shift registers (`sa`<=`a`, `sb`<=`b`), clears the borrow register and bit counter, and moves to RUN.
  - `start`=0 stays in IDLE.
- RUN, each cycle:
  - First half-subtractor: `d1 = sa[0]^sb[0]`, `b1 = ~sa[0]&sb[0]`.
  - Second half-subtractor: `d = d1^brw`, `b2 = ~d1&brw`.
  - Borrow update: `brw <= b1|b2`.
  - Shifts: `d` shifts into `dif` at the MSB (`dif <= {d, dif[WIDTH-1:1]}`); `sa` and `sb` shift right by 1.
  - Counter increments.
  - After the WIDTH-th bit is processed, `bor` <= the final borrow and the state moves to DONE.
- DONE: lasts exactly one cycle.
  - `start`=1 accepts a new operation exactly as IDLE does and moves to RUN (back-to-back operation).
  - `start`=0 moves to IDLE.
- `start` in RUN is ignored. It is not queued, and the operands are not re-captured.
- `dif` is a partial shift value during RUN; consumers must only sample it while `done`=1 or afterwards in IDLE.
- `bor` updates only on the DONE-entry edge, so it holds the previous result throughout RUN.
- Counter width is clog2(WIDTH+1) bits; it never wraps within an operation.

## Timing
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE immediately.
  - `busy`=0, `done`=0, `dif`=0, `bor`=0; borrow register, counter, `sa` and `sb` are 0.
  - An in-flight operation is discarded with no `done`.
- Release of `rst` takes effect at the first rising edge with `rst`=0.
- Let edge E0 be the edge where `start` is accepted:
  - E0+1 .. E0+WIDTH: bits 0..WIDTH-1 are processed.
  - `busy`=1 from after E0 until after E0+WIDTH.
  - `done`=1 for exactly the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency from accept to `done` is WIDTH cycles.
- Throughput with back-to-back starts in DONE is one result per WIDTH+1 cycles.
- `busy` and `done` are never both high.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with WIDTH=8, a=0x05, b=0x03 -> `busy` high for 8 cycles, then `done` for 1 cycle with `dif`=0x02, `bor`=0.
- a=0x03, b=0x05 -> `dif`=0xFE, `bor`=1.
- Edge cases:
  - a=0x00, b=0x01 -> `dif`=0xFF, `bor`=1.
  - a=0xFF, b=0xFF -> `dif`=0x00, `bor`=0.
  - a=0x00, b=0x00 -> `dif`=0x00, `bor`=0.
- `start` pulsed on cycle 3 of RUN with different operands -> ignored; first result is unchanged and `done` fires at the original time.
- `start` held high continuously with new operands presented in each DONE cycle -> consecutive correct results, `done` every 9 cycles; `dif`/`bor` held stable in IDLE once `start` drops.
- Assert `rst` on cycle 4 of RUN -> outputs are 0 immediately and no `done` follows. A fresh start with a=0x80, b=0x7F then gives `dif`=0x01, `bor`=0.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller: one full-subtractor cell (two half-subtractors
// plus OR of borrows) fed LSB-first from shift registers, with start/busy/done.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bor
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] dif_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bor_q;
  logic             busy_q;
  logic             done_q;

  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             brw_d;
  logic             accept;

  // Shared full-subtractor cell operating on the current LSBs
  assign d1     = sa_q[0] ^ sb_q[0];
  assign b1     = ~sa_q[0] & sb_q[0];
  assign d      = d1 ^ brw_q;
  assign b2     = ~d1 & brw_q;
  assign brw_d  = b1 | b2;
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      dif_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        sa_q    <= a;
        sb_q    <= b;
        brw_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        brw_q <= brw_d;
        dif_q <= {d, dif_q[WIDTH-1:1]};
        sa_q  <= sa_q >> 1;
        sb_q  <= sb_q >> 1;
        cnt_q <= cnt_q + CW'(1);
        // Last bit: publish the final borrow alongside the completed difference
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          bor_q   <= brw_d;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dif  = dif_q;
  assign bor  = bor_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8) with a queue-based scoreboard
// of expected {dif, bor} results checked at each done pulse.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] dif;
    logic         bor;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] dif;
  logic         bor;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .dif  (dif),
    .bor  (bor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.dif = W'(av - bv);
    e.bor = (av < bv);
    exp_q.push_back(e);
  endtask

  // Present operands with start high for one edge; return at first RUN negedge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    push_exp(av, bv);
    @(negedge clk);
    start = 1'b0;
    check("bor_hold_run", 32'(bor), 32'(last_exp.bor));
  endtask

  // Count RUN cycles (first RUN negedge already reached); optional mid-run start pulse
  task automatic wait_run(input int pulse_at, input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input bit hold);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == pulse_at) begin
        start = 1'b1; a = pa; b = pb;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(W));
  endtask

  task automatic check_done();
    exp_t e;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("dif", 32'(dif), 32'(e.dif));
      check("bor", 32'(bor), 32'(e.bor));
      last_exp = e;
    end
  endtask

  task automatic single_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    issue(av, bv);
    wait_run(0, '0, '0, 1'b0);
    check_done();
    @(negedge clk);
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    check("idle_dif_hold", 32'(dif), 32'(last_exp.dif));
  endtask

  initial begin
    int t_prev;
    int seen_done;
    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    bb_a = '{8'h9C, 8'h10, 8'h7F};
    bb_b = '{8'h1D, 8'hF0, 8'h7F};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dif", 32'(dif), 32'd0);
    check("rst_bor", 32'(bor), 32'd0);
    rst = 1'b0;

    // Basic and edge-case operands
    single_op(8'h05, 8'h03);
    single_op(8'h03, 8'h05);
    single_op(8'h00, 8'h01);
    single_op(8'hFF, 8'hFF);
    single_op(8'h00, 8'h00);
    single_op(8'hA5, 8'h5A);

    // start pulsed during RUN cycle 3 must be ignored
    issue(8'h10, 8'h01);
    wait_run(3, 8'h33, 8'h44, 1'b0);
    check_done();
    @(negedge clk);
    check("ignored_start_busy", 32'(busy), 32'd0);
    check("ignored_start_done", 32'(done), 32'd0);
    check("ignored_start_q", 32'(exp_q.size()), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = bb_a[0]; b = bb_b[0];
    push_exp(bb_a[0], bb_b[0]);
    t_prev = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_run(0, '0, '0, 1'b1);
      check_done();
      if (t_prev >= 0) check("bb_period", 32'(cyc - t_prev), 32'(W + 1));
      t_prev = cyc;
      if (k < 2) begin
        a = bb_a[k+1]; b = bb_b[k+1];
        push_exp(bb_a[k+1], bb_b[k+1]);
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("bb_idle_busy", 32'(busy), 32'd0);
    check("bb_idle_dif_hold", 32'(dif), 32'(last_exp.dif));
    check("bb_idle_bor_hold", 32'(bor), 32'(last_exp.bor));

    // Async reset in RUN cycle 4 discards the operation
    issue(8'h12, 8'h34);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dif", 32'(dif), 32'd0);
    check("midrst_bor", 32'(bor), 32'd0);
    void'(exp_q.pop_back());
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);

    single_op(8'h80, 8'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
